// File: rtl/stream_packer.sv
// Packs a single-element ready/valid stream into MAX_OUTPUTS-lane words with a
// contiguous low-lane keep mask; words close when full, on in_last, or on flush.
module stream_packer #(
  parameter int  BIT_WIDTH   = 32,
  parameter int  MAX_OUTPUTS = 4,
  parameter type DATA_TYPE   = logic [BIT_WIDTH-1:0]
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               in_valid,
  input  DATA_TYPE                           in_data,
  input  logic                               in_last,
  output logic                               in_ready,
  input  logic                               flush,
  output logic                               out_valid,
  output DATA_TYPE [0:MAX_OUTPUTS-1]         out_data,
  output logic [MAX_OUTPUTS-1:0]             out_keep,
  output logic                               out_last,
  input  logic                               out_ready
);

  localparam int              CW       = $clog2(MAX_OUTPUTS + 1);
  localparam logic [CW-1:0]   CNT_FULL = CW'(MAX_OUTPUTS);

  if (MAX_OUTPUTS < 2) begin : g_check_lanes
    $fatal(1, "stream_packer: MAX_OUTPUTS must be >= 2");
  end
  if ($bits(DATA_TYPE) != BIT_WIDTH) begin : g_check_width
    $fatal(1, "stream_packer: $bits(DATA_TYPE) must equal BIT_WIDTH");
  end

  DATA_TYPE [0:MAX_OUTPUTS-1] lane_reg;
  DATA_TYPE [0:MAX_OUTPUTS-1] packed_word;
  logic [CW-1:0]              acnt_reg, acnt_next, cnt_base;
  logic                       sealed_reg, sealed_next;
  logic                       sealed_last_reg, sealed_last_next;
  logic [MAX_OUTPUTS-1:0]     lane_used, lane_we;
  logic                       xfer, accept, open_base;

  DATA_TYPE [0:MAX_OUTPUTS-1] out_data_reg;
  logic [MAX_OUTPUTS-1:0]     out_keep_reg;
  logic                       out_last_reg, out_valid_reg;

  assign xfer      = sealed_reg && (!out_valid_reg || out_ready);
  assign open_base = !sealed_reg || xfer;
  assign in_ready  = !rst && open_base;
  assign accept    = in_valid && in_ready;
  // A word leaving on this edge frees the buffer, so a new element starts at lane 0.
  assign cnt_base  = xfer ? '0 : acnt_reg;
  assign acnt_next = cnt_base + {{(CW-1){1'b0}}, accept};

  for (genvar gi = 0; gi < MAX_OUTPUTS; gi++) begin : g_lane
    assign lane_used[gi] = CW'(gi) < acnt_reg;
    assign lane_we[gi]   = accept && (cnt_base == CW'(gi));
  end

  always_comb begin
    packed_word = '0;
    for (int i = 0; i < MAX_OUTPUTS; i++) begin
      if (lane_used[i]) packed_word[i] = lane_reg[i];
    end
  end

  always_comb begin
    sealed_next      = sealed_reg && !xfer;
    sealed_last_next = sealed_last_reg;
    if (open_base && ((accept && (acnt_next == CNT_FULL || in_last)) ||
                      (flush && acnt_next != '0))) begin
      sealed_next      = 1'b1;
      sealed_last_next = accept && in_last;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acnt_reg        <= '0;
      sealed_reg      <= 1'b0;
      sealed_last_reg <= 1'b0;
      lane_reg        <= '0;
    end else begin
      acnt_reg        <= acnt_next;
      sealed_reg      <= sealed_next;
      sealed_last_reg <= sealed_last_next;
      for (int i = 0; i < MAX_OUTPUTS; i++) begin
        if (lane_we[i]) lane_reg[i] <= in_data;
      end
    end
  end

  // Output slot: refilled on xfer, otherwise only out_valid drops when drained.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_data_reg  <= '0;
      out_keep_reg  <= '0;
      out_last_reg  <= 1'b0;
      out_valid_reg <= 1'b0;
    end else if (xfer) begin
      out_data_reg  <= packed_word;
      out_keep_reg  <= lane_used;
      out_last_reg  <= sealed_last_reg;
      out_valid_reg <= 1'b1;
    end else if (out_valid_reg && out_ready) begin
      out_valid_reg <= 1'b0;
    end
  end

  assign out_data  = out_data_reg;
  assign out_keep  = out_keep_reg;
  assign out_last  = out_last_reg;
  assign out_valid = out_valid_reg;

endmodule

// File: tb/tb_stream_packer.sv
// Directed and randomized checks of stream_packer against a queue-based word model.
module tb_stream_packer;
  localparam int W = 32;
  localparam int N = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid = 1'b0;
  logic [W-1:0]     in_data = '0;
  logic             in_last = 1'b0;
  logic             in_ready;
  logic             flush = 1'b0;
  logic             out_valid;
  logic [0:N-1][W-1:0] out_data;
  logic [N-1:0]     out_keep;
  logic             out_last;
  logic             out_ready = 1'b0;

  always #5 clk = ~clk;

  stream_packer #(.BIT_WIDTH(W), .MAX_OUTPUTS(N)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_data(in_data), .in_last(in_last), .in_ready(in_ready),
    .flush(flush),
    .out_valid(out_valid), .out_data(out_data), .out_keep(out_keep),
    .out_last(out_last), .out_ready(out_ready)
  );

  int n_assert = 0;
  int n_fail   = 0;
  int n_words  = 0;

  // Reference model: open word as a queue, one held output word.
  int           cur[$];
  bit           m_sealed = 0, m_slast = 0, m_valid = 0, m_last = 0;
  logic [127:0] m_data = '0;
  logic [N-1:0] m_keep = '0;
  logic [32:0]  acc_q[$];
  logic [32:0]  pop_q[$];
  bit           acc_b;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    cur.delete();
    m_sealed = 0; m_slast = 0; m_valid = 0; m_last = 0;
    m_data = '0; m_keep = '0;
    acc_q.delete(); pop_q.delete();
  endtask

  task automatic check_out(input string tag);
    chk({tag, "_valid"}, out_valid, m_valid);
    chk({tag, "_data"},  out_data,  m_data);
    chk({tag, "_keep"},  out_keep,  m_keep);
    chk({tag, "_last"},  out_last,  m_last);
  endtask

  task automatic step(input bit v, input logic [W-1:0] d, input bit l, input bit f,
                      input bit ordy, output bit acc);
    bit m_xfer, m_rdy, acc_m;
    int k;
    in_valid = v; in_data = d; in_last = l; flush = f; out_ready = ordy;
    #1;
    m_xfer = m_sealed && (!m_valid || ordy);
    m_rdy  = !m_sealed || m_xfer;
    chk("in_ready", in_ready, m_rdy);
    acc = v && in_ready;
    if (out_valid && ordy) begin
      k = $countones(out_keep);
      chk("keep_shape", (out_keep == N'((1 << k) - 1)) && (k > 0), 1'b1);
      for (int i = 0; i < k; i++)
        pop_q.push_back({out_last && (i == k - 1), out_data[i]});
      n_words++;
      $display("word %0d: keep=%b last=%b data=%h", n_words, out_keep, out_last, out_data);
    end
    @(posedge clk);
    if (m_xfer) begin
      m_data = '0;
      foreach (cur[i]) m_data[127 - 32*i -: 32] = cur[i];
      m_keep   = N'((1 << cur.size()) - 1);
      m_last   = m_slast;
      m_valid  = 1;
      m_sealed = 0;
      cur.delete();
    end else if (m_valid && ordy) begin
      m_valid = 0;
    end
    acc_m = v && m_rdy;
    if (acc_m) begin
      cur.push_back(d);
      acc_q.push_back({l, d});
    end
    if (!m_sealed && ((acc_m && (cur.size() == N || l)) || (f && cur.size() > 0))) begin
      m_sealed = 1;
      m_slast  = acc_m && l;
    end
    #1;
    check_out("out");
  endtask

  task automatic idle(input int n);
    bit a;
    for (int i = 0; i < n; i++) step(0, '0, 0, 0, 1, a);
  endtask

  initial begin
    int seq;
    model_clear();
    #12;
    chk("rst_in_ready", in_ready, 1'b0);
    check_out("rst");
    @(posedge clk); #1; rst = 0;

    // Full words, no gaps
    for (int k = 1; k <= 8; k++) step(1, W'(k), 0, 0, 1, acc_b);
    idle(2);

    // Early close on in_last
    step(1, 10, 0, 0, 1, acc_b);
    step(1, 11, 0, 0, 1, acc_b);
    step(1, 12, 1, 0, 1, acc_b);
    idle(1);
    step(1, 7, 1, 0, 1, acc_b);
    step(0, 0, 0, 0, 0, acc_b);
    chk("single_data", out_data, {32'd7, 32'd0, 32'd0, 32'd0});
    chk("single_keep", out_keep, 4'b0001);
    idle(1);

    // Backpressure
    for (int k = 1; k <= 9; k++) step(1, W'(k), 0, 0, 0, acc_b);
    chk("bp_acc9_blocked", acc_b, 1'b0);
    chk("bp_hold", out_data, {32'd1, 32'd2, 32'd3, 32'd4});
    step(1, 9, 0, 0, 1, acc_b);
    chk("bp_acc9_taken", acc_b, 1'b1);
    chk("bp_next", out_data, {32'd5, 32'd6, 32'd7, 32'd8});
    step(0, 0, 0, 1, 1, acc_b);
    idle(2);

    // Flush
    step(1, 20, 0, 0, 1, acc_b);
    step(1, 21, 0, 0, 1, acc_b);
    idle(1);
    step(0, 0, 0, 1, 1, acc_b);
    idle(2);
    step(0, 0, 0, 1, 1, acc_b);
    idle(1);
    chk("flush_empty_valid", out_valid, 1'b0);
    step(1, 30, 0, 1, 1, acc_b);
    step(0, 0, 0, 0, 0, acc_b);
    chk("flush_acc_keep", out_keep, 4'b0001);
    idle(2);

    // Reset mid-operation
    for (int k = 1; k <= 6; k++) step(1, W'(k), 0, 0, 0, acc_b);
    #2 rst = 1;
    #1;
    chk("arst_valid", out_valid, 1'b0);
    chk("arst_in_ready", in_ready, 1'b0);
    chk("arst_keep", out_keep, '0);
    chk("arst_data", out_data, '0);
    model_clear();
    @(posedge clk); #1; rst = 0;
    for (int k = 5; k <= 8; k++) step(1, W'(k), 0, 0, 1, acc_b);
    step(0, 0, 0, 0, 0, acc_b);
    chk("post_rst_word", out_data, {32'd5, 32'd6, 32'd7, 32'd8});
    idle(2);

    // Random soak
    seq = 100;
    for (int c = 0; c < 400; c++) begin
      step($urandom_range(0, 3) != 0, W'(seq), $urandom_range(0, 5) == 0,
           $urandom_range(0, 9) == 0, $urandom_range(0, 3) != 0, acc_b);
      if (acc_b) seq++;
    end
    step(0, 0, 0, 1, 1, acc_b);
    idle(3);

    chk("stream_len", pop_q.size(), acc_q.size());
    foreach (acc_q[i]) begin
      if (i < pop_q.size()) chk("stream_elem", pop_q[i], acc_q[i]);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
